// File: rtl/bp_cce_hybrid_req_router_pkg.sv
// Shared types for the hybrid CCE request router: header layout, CCE mode,
// data-control entry and the physical memory attribute (PMA) helper.
package bp_cce_hybrid_req_router_pkg;

   localparam int paddr_width_gp    = 40;
   localparam int lce_id_width_gp   = 4;
   localparam int dword_width_gp    = 64;
   localparam int max_chan_width_gp = 4;

   localparam logic [paddr_width_gp-1:0]    dram_base_addr_gp = 40'h00_8000_0000;
   localparam logic [max_chan_width_gp-1:0] coh_chan_gp       = '0;

   typedef enum logic [0:0] {
      e_cce_mode_normal   = 1'b0,
      e_cce_mode_uncached = 1'b1
   } bp_cce_mode_e;

   typedef enum logic [2:0] {
      e_bedrock_req_rd_miss = 3'b000,
      e_bedrock_req_wr_miss = 3'b001,
      e_bedrock_req_uc_rd   = 3'b010,
      e_bedrock_req_uc_wr   = 3'b011
   } bp_lce_req_type_e;

   typedef struct packed {
      bp_lce_req_type_e            msg_type;
      logic [lce_id_width_gp-1:0]  src_id;
      logic [2:0]                  size;
      logic [paddr_width_gp-1:0]   addr;
   } bp_lce_req_header_s;

   localparam int lce_req_header_width_gp = $bits(bp_lce_req_header_s);

   typedef struct packed {
      logic               has_data;
      bp_lce_req_header_s hdr;
   } bp_hdr_entry_s;

   typedef struct packed {
      logic                         has_data;
      logic [max_chan_width_gp-1:0] chan;
   } bp_cce_dctrl_s;

   // DRAM space is cacheable; everything below it is I/O.
   function automatic logic bp_pma_cacheable(input logic [paddr_width_gp-1:0] addr);
      return addr >= dram_base_addr_gp;
   endfunction

   function automatic logic bp_is_coherent_req(input bp_lce_req_type_e t);
      return (t == e_bedrock_req_rd_miss) || (t == e_bedrock_req_wr_miss);
   endfunction

endpackage

// File: rtl/bp_cce_hybrid_req_router_route.sv
// Channel select for one request: channel 0 for coherent traffic, otherwise
// 1 + the address interleave field for uncacheable traffic.
module bp_cce_hybrid_req_router_route
   import bp_cce_hybrid_req_router_pkg::*;
   #(parameter int num_out_p    = 3
    ,parameter int uc_sel_lsb_p = 12
    ,localparam int chan_w_lp   = $clog2(num_out_p))
   (input  logic [paddr_width_gp-1:0] addr_i
   ,input  bp_cce_mode_e              cce_mode_i
   ,output logic                      pma_cacheable_o
   ,output logic [chan_w_lp-1:0]      chan_o
   );

   localparam int sel_w_lp = $clog2(num_out_p-1);

   logic                 cacheable;
   logic [chan_w_lp-1:0] uc_chan;

   assign pma_cacheable_o = bp_pma_cacheable(addr_i);
   assign cacheable       = pma_cacheable_o & (cce_mode_i == e_cce_mode_normal);

   generate
      if (sel_w_lp == 0) begin : g_single_uc
         assign uc_chan = chan_w_lp'(1);
      end else begin : g_interleave_uc
         assign uc_chan = chan_w_lp'(1) + chan_w_lp'(addr_i[uc_sel_lsb_p +: sel_w_lp]);
      end
   endgenerate

   assign chan_o = cacheable ? chan_w_lp'(coh_chan_gp) : uc_chan;

endmodule

// File: rtl/bp_cce_hybrid_req_router.sv
// N-way LCE request splitter: header FIFO, route, data-control FIFO steering data beats.
// Optional per-channel saturating header counters: define BP_CCE_HYBRID_REQ_ROUTER_PERF_EN.
module bp_cce_hybrid_req_router
   import bp_cce_hybrid_req_router_pkg::*;
   #(parameter int lce_data_width_p = dword_width_gp
    ,parameter int num_out_p        = 3
    ,parameter int hdr_els_p        = 2
    ,parameter int data_ctrl_els_p  = 4
    ,parameter int uc_sel_lsb_p     = 12
    ,localparam int hdr_w_lp        = lce_req_header_width_gp
    ,localparam int chan_w_lp       = $clog2(num_out_p))
   (input  logic                                clk_i
   ,input  logic                                reset_n_i
   ,input  bp_cce_mode_e                        cce_mode_i
   ,input  logic                                stall_i
   ,output logic                                empty_o
   ,input  logic [hdr_w_lp-1:0]                 lce_req_header_i
   ,input  logic                                lce_req_header_v_i
   ,output logic                                lce_req_header_ready_and_o
   ,input  logic                                lce_req_has_data_i
   ,input  logic [lce_data_width_p-1:0]         lce_req_data_i
   ,input  logic                                lce_req_data_v_i
   ,output logic                                lce_req_data_ready_and_o
   ,input  logic                                lce_req_last_i
   ,output logic [num_out_p*hdr_w_lp-1:0]       req_header_o
   ,output logic [num_out_p-1:0]                req_header_v_o
   ,input  logic [num_out_p-1:0]                req_header_ready_and_i
   ,output logic [num_out_p-1:0]                req_has_data_o
   ,output logic [num_out_p*lce_data_width_p-1:0] req_data_o
   ,output logic [num_out_p-1:0]                req_data_v_o
   ,input  logic [num_out_p-1:0]                req_data_ready_and_i
   ,output logic [num_out_p-1:0]                req_last_o
`ifdef BP_CCE_HYBRID_REQ_ROUTER_PERF_EN
   ,output logic [num_out_p*32-1:0]             perf_hdr_count_o
`endif
   );

   localparam int hptr_w_lp = $clog2(hdr_els_p);
   localparam int hcnt_w_lp = $clog2(hdr_els_p+1);
   localparam int dptr_w_lp = $clog2(data_ctrl_els_p);
   localparam int dcnt_w_lp = $clog2(data_ctrl_els_p+1);

   bp_hdr_entry_s        hdr_mem_q [hdr_els_p];
   logic [hptr_w_lp-1:0] hwptr_q, hwptr_d, hrptr_q, hrptr_d;
   logic [hcnt_w_lp-1:0] hcnt_q, hcnt_d;

   bp_cce_dctrl_s        dctrl_mem_q [data_ctrl_els_p];
   logic [dptr_w_lp-1:0] dwptr_q, dwptr_d, drptr_q, drptr_d;
   logic [dcnt_w_lp-1:0] dcnt_q, dcnt_d;

   bp_hdr_entry_s        head;
   bp_cce_dctrl_s        dhead;
   logic                 head_v, hdr_fifo_ready, hdr_enq, hdr_deq, hdr_dispatch_v;
   logic                 dctrl_v, dctrl_ready, dctrl_enq, dctrl_deq;
   logic                 data_sel_v, data_hs, pma_cacheable;
   logic [chan_w_lp-1:0] hdr_chan;
   logic [num_out_p-1:0] data_sel_oh;

   assign head           = hdr_mem_q[hrptr_q];
   assign head_v         = (hcnt_q != '0);
   assign hdr_fifo_ready = (hcnt_q != hcnt_w_lp'(hdr_els_p));

   assign lce_req_header_ready_and_o = reset_n_i & ~stall_i & hdr_fifo_ready;
   assign hdr_enq = lce_req_header_v_i & lce_req_header_ready_and_o;

   bp_cce_hybrid_req_router_route
      #(.num_out_p(num_out_p), .uc_sel_lsb_p(uc_sel_lsb_p))
      route
      (.addr_i(head.hdr.addr)
      ,.cce_mode_i(cce_mode_i)
      ,.pma_cacheable_o(pma_cacheable)
      ,.chan_o(hdr_chan)
      );

   assign dhead       = dctrl_mem_q[drptr_q];
   assign dctrl_v     = (dcnt_q != '0);
   assign dctrl_ready = (dcnt_q != dcnt_w_lp'(data_ctrl_els_p));
   assign data_sel_v  = dctrl_v & dhead.has_data;

   // A header only leaves once its data-control slot is guaranteed.
   assign hdr_dispatch_v = head_v & dctrl_ready;

   genvar gi;
   generate
      for (gi = 0; gi < num_out_p; gi++) begin : g_chan
         assign req_header_v_o[gi] = hdr_dispatch_v & (hdr_chan == chan_w_lp'(gi));
         assign req_header_o[gi*hdr_w_lp +: hdr_w_lp] = head.hdr;
         assign req_has_data_o[gi] = head.has_data;
         assign data_sel_oh[gi]    = data_sel_v & (dhead.chan == max_chan_width_gp'(gi));
         assign req_data_v_o[gi]   = data_sel_oh[gi] & lce_req_data_v_i;
         assign req_data_o[gi*lce_data_width_p +: lce_data_width_p] = lce_req_data_i;
         assign req_last_o[gi]     = lce_req_last_i;
      end
   endgenerate

   assign hdr_deq   = |(req_header_v_o & req_header_ready_and_i);
   assign dctrl_enq = hdr_deq;

   assign lce_req_data_ready_and_o = |(data_sel_oh & req_data_ready_and_i);
   assign data_hs   = lce_req_data_v_i & lce_req_data_ready_and_o;
   assign dctrl_deq = dctrl_v & (~dhead.has_data | (data_hs & lce_req_last_i));

   assign empty_o = ~head_v & ~dctrl_v;

   always_comb begin
      hwptr_d = hwptr_q;
      hrptr_d = hrptr_q;
      dwptr_d = dwptr_q;
      drptr_d = drptr_q;
      hcnt_d  = hcnt_q + hcnt_w_lp'(hdr_enq) - hcnt_w_lp'(hdr_deq);
      dcnt_d  = dcnt_q + dcnt_w_lp'(dctrl_enq) - dcnt_w_lp'(dctrl_deq);
      if (hdr_enq)
         hwptr_d = (hwptr_q == hptr_w_lp'(hdr_els_p-1)) ? '0 : hwptr_q + hptr_w_lp'(1);
      if (hdr_deq)
         hrptr_d = (hrptr_q == hptr_w_lp'(hdr_els_p-1)) ? '0 : hrptr_q + hptr_w_lp'(1);
      if (dctrl_enq)
         dwptr_d = (dwptr_q == dptr_w_lp'(data_ctrl_els_p-1)) ? '0 : dwptr_q + dptr_w_lp'(1);
      if (dctrl_deq)
         drptr_d = (drptr_q == dptr_w_lp'(data_ctrl_els_p-1)) ? '0 : drptr_q + dptr_w_lp'(1);
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         hwptr_q <= '0;
         hrptr_q <= '0;
         hcnt_q  <= '0;
         dwptr_q <= '0;
         drptr_q <= '0;
         dcnt_q  <= '0;
      end else begin
         hwptr_q <= hwptr_d;
         hrptr_q <= hrptr_d;
         hcnt_q  <= hcnt_d;
         dwptr_q <= dwptr_d;
         drptr_q <= drptr_d;
         dcnt_q  <= dcnt_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (hdr_enq)
         hdr_mem_q[hwptr_q] <= {lce_req_has_data_i, lce_req_header_i};
      if (dctrl_enq)
         dctrl_mem_q[dwptr_q] <= {head.has_data, max_chan_width_gp'(hdr_chan)};
   end

`ifdef BP_CCE_HYBRID_REQ_ROUTER_PERF_EN
   generate
      for (gi = 0; gi < num_out_p; gi++) begin : g_perf
         logic [31:0] cnt_q;
         always_ff @(posedge clk_i or negedge reset_n_i) begin
            if (!reset_n_i)
               cnt_q <= '0;
            else if (req_header_v_o[gi] & req_header_ready_and_i[gi] & (cnt_q != 32'hFFFF_FFFF))
               cnt_q <= cnt_q + 32'd1;
         end
         assign perf_hdr_count_o[gi*32 +: 32] = cnt_q;
      end
   endgenerate
`endif

   assert property (@(posedge clk_i) disable iff (!reset_n_i)
      head_v |-> !(bp_is_coherent_req(head.hdr.msg_type) && !pma_cacheable));

   assert property (@(posedge clk_i) disable iff (!reset_n_i)
      lce_req_data_v_i |-> data_sel_v);

endmodule

// File: tb/tb_bp_cce_hybrid_req_router.sv
// Directed bench for bp_cce_hybrid_req_router (num_out_p=3, hdr_els_p=2, data_ctrl_els_p=4).
module tb_bp_cce_hybrid_req_router;
   import bp_cce_hybrid_req_router_pkg::*;

   localparam int N  = 3;
   localparam int DW = 64;
   localparam int HW = lce_req_header_width_gp;

   logic           clk = 1'b0;
   logic           reset_n = 1'b0;
   bp_cce_mode_e   mode = e_cce_mode_normal;
   logic           stall = 1'b0;
   logic           empty;
   logic [HW-1:0]  hdr_i = '0;
   logic           hdr_v = 1'b0;
   logic           hdr_rdy_o;
   logic           has_data = 1'b0;
   logic [DW-1:0]  data_i = '0;
   logic           data_v = 1'b0;
   logic           data_rdy_o;
   logic           last = 1'b0;
   logic [N*HW-1:0] req_header_o;
   logic [N-1:0]   hv;
   logic [N-1:0]   hdr_rdy = '0;
   logic [N-1:0]   req_has_data_o;
   logic [N*DW-1:0] req_data_o;
   logic [N-1:0]   dv;
   logic [N-1:0]   data_rdy = '0;
   logic [N-1:0]   req_last_o;
`ifdef BP_CCE_HYBRID_REQ_ROUTER_PERF_EN
   logic [N*32-1:0] perf_cnt;
`endif

   always #5 clk = ~clk;

   bp_cce_hybrid_req_router #(.num_out_p(N), .hdr_els_p(2), .data_ctrl_els_p(4)) dut
      (.clk_i(clk)
      ,.reset_n_i(reset_n)
      ,.cce_mode_i(mode)
      ,.stall_i(stall)
      ,.empty_o(empty)
      ,.lce_req_header_i(hdr_i)
      ,.lce_req_header_v_i(hdr_v)
      ,.lce_req_header_ready_and_o(hdr_rdy_o)
      ,.lce_req_has_data_i(has_data)
      ,.lce_req_data_i(data_i)
      ,.lce_req_data_v_i(data_v)
      ,.lce_req_data_ready_and_o(data_rdy_o)
      ,.lce_req_last_i(last)
      ,.req_header_o(req_header_o)
      ,.req_header_v_o(hv)
      ,.req_header_ready_and_i(hdr_rdy)
      ,.req_has_data_o(req_has_data_o)
      ,.req_data_o(req_data_o)
      ,.req_data_v_o(dv)
      ,.req_data_ready_and_i(data_rdy)
      ,.req_last_o(req_last_o)
`ifdef BP_CCE_HYBRID_REQ_ROUTER_PERF_EN
      ,.perf_hdr_count_o(perf_cnt)
`endif
      );

   int n_checks = 0;
   int n_errs   = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end else begin
         $display("ok   %s value=%h", tag, got);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic bp_lce_req_header_s mk_hdr(input bp_lce_req_type_e t, input logic [3:0] src,
                                                  input logic [39:0] addr);
      bp_lce_req_header_s h;
      h.msg_type = t;
      h.src_id   = src;
      h.size     = 3'd3;
      h.addr     = addr;
      return h;
   endfunction

   function automatic logic [HW-1:0] hdr_at(input int ch);
      return req_header_o[ch*HW +: HW];
   endfunction

   // Single no-data header: dispatch the cycle after enqueue, dctrl drains one cycle later.
   task automatic one_hdr(input string tag, input bp_lce_req_type_e t, input logic [39:0] addr,
                          input logic [2:0] exp_v);
      bp_lce_req_header_s h;
      h = mk_hdr(t, 4'h1, addr);
      hdr_i = h; hdr_v = 1'b1; has_data = 1'b0;
      #1 chk({tag, "_rdy"}, 64'(hdr_rdy_o), 64'd1);
      step();
      hdr_v = 1'b0;
      #1 chk({tag, "_hv"}, 64'(hv), 64'(exp_v));
      chk({tag, "_hdr"}, 64'(hdr_at(0)), 64'(h));
      step();
      chk({tag, "_hv_clr"}, 64'(hv), 64'd0);
      chk({tag, "_busy"}, 64'(empty), 64'd0);
      step();
      chk({tag, "_empty"}, 64'(empty), 64'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

   initial begin
      bp_lce_req_header_s h, h1, h2, h3, g1, g2;
      bp_lce_req_header_s d [5];

      // reset state
      #2;
      chk("rst_empty", 64'(empty), 64'd1);
      chk("rst_hdr_rdy", 64'(hdr_rdy_o), 64'd0);
      chk("rst_hv", 64'(hv), 64'd0);
      chk("rst_dv", 64'(dv), 64'd0);
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      hdr_rdy = 3'b111; data_rdy = 3'b111;
      #1 chk("post_rst_rdy", 64'(hdr_rdy_o), 64'd1);

      // normal mode routing
      one_hdr("t1_coh_rd", e_bedrock_req_rd_miss, 40'h00_8000_1000, 3'b001);
      one_hdr("t1_uc_lo", e_bedrock_req_uc_rd, 40'h00_0000_0000, 3'b010);
      one_hdr("t1_uc_pma", e_bedrock_req_uc_rd, 40'h00_8000_0000, 3'b001);

      // uncached store with one data beat on channel 2
      h = mk_hdr(e_bedrock_req_uc_wr, 4'h2, 40'h00_0000_1000);
      hdr_i = h; hdr_v = 1'b1; has_data = 1'b1;
      step();
      hdr_v = 1'b0; has_data = 1'b0;
      #1 chk("t2_hv", 64'(hv), 64'b100);
      chk("t2_has_data", 64'(req_has_data_o[2]), 64'd1);
      chk("t2_hdr", 64'(hdr_at(2)), 64'(h));
      step();
      chk("t2_hv_clr", 64'(hv), 64'd0);
      data_i = 64'hDEAD_BEEF; data_v = 1'b1; last = 1'b1;
      #1 chk("t2_dv", 64'(dv), 64'b100);
      chk("t2_data", req_data_o[2*DW +: DW], 64'hDEAD_BEEF);
      chk("t2_last", 64'(req_last_o[2]), 64'd1);
      chk("t2_drdy", 64'(data_rdy_o), 64'd1);
      step();
      data_v = 1'b0; last = 1'b0;
      #1 chk("t2_empty", 64'(empty), 64'd1);
      chk("t2_dv_clr", 64'(dv), 64'd0);

      // uncached-only mode never uses channel 0
      mode = e_cce_mode_uncached;
      one_hdr("t3_uc_b0", e_bedrock_req_uc_rd, 40'h00_8000_0000, 3'b010);
      one_hdr("t3_uc_b1", e_bedrock_req_uc_rd, 40'h00_8000_1000, 3'b100);
      one_hdr("t3_miss_b1", e_bedrock_req_rd_miss, 40'h00_8000_1000, 3'b100);
      mode = e_cce_mode_normal;

      // channel 1 back-pressure: buffer fills, order preserved after release
      hdr_rdy = 3'b101;
      h1 = mk_hdr(e_bedrock_req_uc_rd, 4'h1, 40'h0);
      h2 = mk_hdr(e_bedrock_req_uc_rd, 4'h2, 40'h0);
      h3 = mk_hdr(e_bedrock_req_uc_rd, 4'h3, 40'h0);
      hdr_i = h1; hdr_v = 1'b1;
      step();
      hdr_i = h2;
      step();
      hdr_i = h3;
      #1 chk("t4_full_rdy", 64'(hdr_rdy_o), 64'd0);
      chk("t4_held_hv", 64'(hv), 64'b010);
      chk("t4_held_hdr", 64'(hdr_at(1)), 64'(h1));
      repeat (4) step();
      chk("t4_still_hdr", 64'(hdr_at(1)), 64'(h1));
      chk("t4_still_rdy", 64'(hdr_rdy_o), 64'd0);
      hdr_rdy = 3'b111;
      #1 chk("t4_rel_hdr", 64'(hdr_at(1)), 64'(h1));
      step();
      chk("t4_h2", 64'(hdr_at(1)), 64'(h2));
      chk("t4_rdy_again", 64'(hdr_rdy_o), 64'd1);
      step();
      hdr_v = 1'b0;
      #1 chk("t4_h3", 64'(hdr_at(1)), 64'(h3));
      chk("t4_h3_hv", 64'(hv), 64'b010);
      step();
      step();
      chk("t4_empty", 64'(empty), 64'd1);

      // data-control FIFO full halts dispatch until a pop
      for (int i = 0; i < 5; i++) begin
         d[i] = mk_hdr(e_bedrock_req_uc_wr, 4'(i), 40'h0);
         hdr_i = d[i]; hdr_v = 1'b1; has_data = 1'b1;
         #1 chk($sformatf("t5_rdy%0d", i), 64'(hdr_rdy_o), 64'd1);
         step();
      end
      hdr_v = 1'b0; has_data = 1'b0;
      #1 chk("t5_halt_hv", 64'(hv), 64'd0);
      chk("t5_head_held", 64'(hdr_at(1)), 64'(d[4]));
      step();
      chk("t5_halt_hv2", 64'(hv), 64'd0);
      data_i = 64'h0; data_v = 1'b1; last = 1'b1;
      #1 chk("t5_d0_dv", 64'(dv), 64'b010);
      chk("t5_d0_hv", 64'(hv), 64'd0);
      step();
      chk("t5_resume_hv", 64'(hv), 64'b010);
      chk("t5_resume_hdr", 64'(hdr_at(1)), 64'(d[4]));
      for (int k = 1; k < 5; k++) begin
         data_i = 64'(k);
         #1 chk($sformatf("t5_d%0d_dv", k), 64'(dv), 64'b010);
         step();
      end
      data_v = 1'b0; last = 1'b0;
      #1 chk("t5_empty", 64'(empty), 64'd1);

      // stall blocks enqueue only; buffered headers drain
      stall = 1'b1;
      #1 chk("t6_stall_idle_rdy", 64'(hdr_rdy_o), 64'd0);
      stall = 1'b0;
      hdr_rdy = 3'b000;
      g1 = mk_hdr(e_bedrock_req_rd_miss, 4'h5, 40'h00_8000_0000);
      g2 = mk_hdr(e_bedrock_req_rd_miss, 4'h6, 40'h00_8000_0040);
      hdr_i = g1; hdr_v = 1'b1;
      step();
      hdr_i = g2;
      step();
      hdr_v = 1'b0;
      stall = 1'b1; hdr_rdy = 3'b111;
      #1 chk("t6_hv", 64'(hv), 64'b001);
      chk("t6_g1", 64'(hdr_at(0)), 64'(g1));
      step();
      chk("t6_stall_rdy", 64'(hdr_rdy_o), 64'd0);
      chk("t6_g2", 64'(hdr_at(0)), 64'(g2));
      chk("t6_g2_hv", 64'(hv), 64'b001);
      step();
      chk("t6_busy", 64'(empty), 64'd0);
      step();
      chk("t6_empty", 64'(empty), 64'd1);
      stall = 1'b0;

      // asynchronous reset in the middle of a data beat
      h = mk_hdr(e_bedrock_req_uc_wr, 4'h7, 40'h00_0000_1000);
      hdr_i = h; hdr_v = 1'b1; has_data = 1'b1;
      step();
      hdr_v = 1'b0; has_data = 1'b0;
      step();
      data_i = 64'h1234; data_v = 1'b1; last = 1'b0;
      #1 chk("t7_dv", 64'(dv), 64'b100);
      #2 reset_n = 1'b0;
      #1 chk("t7_rst_dv", 64'(dv), 64'd0);
      chk("t7_rst_hv", 64'(hv), 64'd0);
      chk("t7_rst_rdy", 64'(hdr_rdy_o), 64'd0);
      chk("t7_rst_drdy", 64'(data_rdy_o), 64'd0);
      chk("t7_rst_empty", 64'(empty), 64'd1);
      data_v = 1'b0;
      step();
      step();
      reset_n = 1'b1;
      #1 chk("t7_post_empty", 64'(empty), 64'd1);
      chk("t7_post_rdy", 64'(hdr_rdy_o), 64'd1);
      one_hdr("t7_restart", e_bedrock_req_uc_rd, 40'h00_0000_1000, 3'b100);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
      $finish;
   end

endmodule
